// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY lane definitions: lane-word layout and the lane phase encoding
// used by the 2:4 demux (and the matching 4:2 mux).
package pcie_phy_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned VALID_BIT = DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PH_A = 2'b01,
    PH_B = 2'b10
  } phase_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } lane_word_t;

endpackage

// File: rtl/lane_phase_tracker.sv
// Lane pair phase tracker: aligns on the first valid in0 word, then alternates
// capture (phase A) and publish (phase B) forever until reset.
module lane_phase_tracker
  import pcie_phy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in0_valid,
  output logic cap_a,
  output logic pub_b
);

  phase_e state;
  phase_e state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobes qualify the edge that ends the current state.
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    pub_b     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in0_valid) begin
          state_nxt = PH_B;
          cap_a     = 1'b1;
        end
      end
      PH_A: begin
        state_nxt = PH_B;
        cap_a     = 1'b1;
      end
      PH_B: begin
        state_nxt = PH_A;
        pub_b     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/demux2x4_behav.sv
// Two-lane to four-lane deserializing demux: restores four time-aligned lanes
// every second clock. DEMUX2X4_HOLD_EN keeps the data field of invalid lanes.
module demux2x4_behav #(
  parameter int unsigned DATA_W = pcie_phy_pkg::DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DATA_W:0] in0,
  input  logic [DATA_W:0] in1,
  output logic [DATA_W:0] out0,
  output logic [DATA_W:0] out1,
  output logic [DATA_W:0] out2,
  output logic [DATA_W:0] out3
);

  localparam int unsigned LW = DATA_W + 1;
`ifdef DEMUX2X4_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          cap_a;
  logic          pub_b;
  logic [LW-1:0] hold0;
  logic [LW-1:0] hold1;

  lane_phase_tracker u_tracker (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0[DATA_W]),
    .cap_a     (cap_a),
    .pub_b     (pub_b)
  );

  // Invalid words publish with valid cleared; data either held or zeroed.
  function automatic logic [LW-1:0] lane_next(input logic [LW-1:0]     w,
                                              input logic [DATA_W-1:0] prev_data);
    if (w[DATA_W]) begin
      return w;
    end
    return HOLD_EN ? {1'b0, prev_data} : '0;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold0 <= '0;
      hold1 <= '0;
    end else if (cap_a) begin
      hold0 <= in0;
      hold1 <= in1;
    end
  end

  // Publish edge: lanes 0/1 from the held pair, lanes 2/3 straight from the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
    end else if (pub_b) begin
      out0 <= lane_next(hold0, out0[DATA_W-1:0]);
      out1 <= lane_next(hold1, out1[DATA_W-1:0]);
      out2 <= lane_next(in0,   out2[DATA_W-1:0]);
      out3 <= lane_next(in1,   out3[DATA_W-1:0]);
    end
  end

endmodule

// File: tb/tb_demux2x4_behav.sv
// Self-checking bench for demux2x4_behav: edge-parity reference model plus
// directed literal checks and randomized traffic with sporadic resets.
module tb_demux2x4_behav;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW:0]   in0, in1;
  logic [DW:0]   out0, out1, out2, out3;

  int errors = 0;
  int checks = 0;

  demux2x4_behav #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .out0  (out0),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3)
  );

  always #5 clk = ~clk;

`ifdef DEMUX2X4_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic check(input string name, input logic [DW:0] got, input logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: after the first valid in0, even edge offsets capture a
  // pair and odd offsets publish it together with the current pair.
  bit          aligned;
  int          n;
  int          pubs = 0;
  logic [DW:0] pa0, pa1;
  logic [DW:0] exp_o [4];

  function automatic logic [DW:0] model_lane(input logic [DW:0] w, input logic [DW:0] prev);
    if (w[DW]) return w;
    if (HOLD)  return {1'b0, prev[DW-1:0]};
    return '0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      aligned = 1'b0;
      n       = 0;
      pa0     = '0;
      pa1     = '0;
      for (int i = 0; i < 4; i++) exp_o[i] = '0;
    end else if (!aligned) begin
      if (in0[DW]) begin
        aligned = 1'b1;
        n       = 0;
        pa0     = in0;
        pa1     = in1;
      end
    end else begin
      n++;
      if (n % 2 == 0) begin
        pa0 = in0;
        pa1 = in1;
      end else begin
        exp_o[0] = model_lane(pa0, exp_o[0]);
        exp_o[1] = model_lane(pa1, exp_o[1]);
        exp_o[2] = model_lane(in0, exp_o[2]);
        exp_o[3] = model_lane(in1, exp_o[3]);
        pubs++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    check("cyc_out0", out0, exp_o[0]);
    check("cyc_out1", out1, exp_o[1]);
    check("cyc_out2", out2, exp_o[2]);
    check("cyc_out3", out3, exp_o[3]);
  end

  task automatic drive(input logic [DW:0] a, input logic [DW:0] b);
    @(negedge clk);
    in0 = a;
    in1 = b;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    in0   = '0;
    in1   = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check4(input string name, input logic [DW:0] e0, input logic [DW:0] e1,
                        input logic [DW:0] e2, input logic [DW:0] e3);
    check({name, "_out0"}, out0, e0);
    check({name, "_out1"}, out1, e1);
    check({name, "_out2"}, out2, e2);
    check({name, "_out3"}, out3, e3);
  endtask

  int p0;

  initial begin
    reset = 1'b0;
    in0   = '0;
    in1   = '0;

    // Reset held with random inputs.
    repeat (5) begin
      @(negedge clk);
      in0 = 9'($urandom);
      in1 = 9'($urandom);
    end
    #1 check4("rst_hold", 9'h000, 9'h000, 9'h000, 9'h000);

    // Release with invalid in0: stays idle.
    @(negedge clk);
    in0   = '0;
    in1   = '0;
    reset = 1'b1;
    repeat (5) drive(9'h000, 9'h000);
    check4("idle", 9'h000, 9'h000, 9'h000, 9'h000);

    // Alignment and ordering, held for two cycles.
    drive(9'h111, 9'h122);
    drive(9'h133, 9'h144);
    drive(9'h000, 9'h000);
    check4("align", 9'h111, 9'h122, 9'h133, 9'h144);
    drive(9'h000, 9'h000);
    check4("align_held", 9'h111, 9'h122, 9'h133, 9'h144);

    // Streaming: 8 back-to-back pairs -> 4 publishes.
    reset_pulse();
    p0 = pubs;
    for (int i = 0; i < 8; i++) begin
      drive(9'(9'h100 + 2 * i), 9'(9'h101 + 2 * i));
      if (i == 2) check4("stream_first", 9'h100, 9'h101, 9'h102, 9'h103);
    end
    drive(9'h000, 9'h000);
    check4("stream_last", 9'h10C, 9'h10D, 9'h10E, 9'h10F);
    checks++;
    if (pubs - p0 != 4) begin
      errors++;
      $display("FAIL stream_pub_count got=%0d expected=4", pubs - p0);
    end

    // Invalid lane on phase B.
    reset_pulse();
    drive(9'h1A1, 9'h1A2);
    drive(9'h1AB, 9'h1AC);
    drive(9'h1B0, 9'h1B1);
    check("inv_pre_out2", out2, 9'h1AB);
    drive(9'h0CD, 9'h1CE);
    drive(9'h1D0, 9'h1D1);
    check4("inv_lane", 9'h1B0, 9'h1B1, HOLD ? 9'h0AB : 9'h000, 9'h1CE);

    // Reset between phase-A capture (1D0/1D1) and phase-B edge.
    @(negedge clk);
    reset = 1'b0;
    #1 check4("midpair_rst", 9'h000, 9'h000, 9'h000, 9'h000);
    in0 = '0;
    in1 = '0;
    @(negedge clk);
    reset = 1'b1;
    drive(9'h000, 9'h000);
    drive(9'h1EE, 9'h1FF);
    drive(9'h101, 9'h102);
    drive(9'h000, 9'h000);
    check4("realign", 9'h1EE, 9'h1FF, 9'h101, 9'h102);

    // Invalid gap of 3 cycles must not disturb phase.
    drive(9'h000, 9'h000);
    drive(9'h000, 9'h000);
    drive(9'h131, 9'h132);
    drive(9'h141, 9'h142);
    drive(9'h151, 9'h152);
    drive(9'h000, 9'h000);
    check4("phase_lock", 9'h141, 9'h142, 9'h151, 9'h152);

    // Random traffic with sporadic resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 49) == 0) reset = 1'b0;
      in0 = 9'($urandom);
      in1 = 9'($urandom);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
